// File: rtl/mux_gate_pkg.sv
// Shared types and widths for the mux-built gate pipeline.
package mux_gate_pkg;

  typedef enum logic [1:0] {
    OP_AND   = 2'd0,
    OP_OR    = 2'd1,
    OP_XOR   = 2'd2,
    OP_NOT_A = 2'd3
  } gate_op_t;

  localparam int unsigned COUNT_W = 16;

endpackage

// File: rtl/mux_gate_unit_pipe_mux2_w.sv
// W-bit 2:1 mux with an independent select per bit; the only gate primitive in the datapath.
module mux2_w
  import mux_gate_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] sel,
  output logic [W-1:0] y
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign y[i] = sel[i] ? d1[i] : d0[i];
  end

endmodule

// File: rtl/mux_gate_unit_pipe.sv
// Pipelined bitwise gate (AND/OR/XOR/NOT_A) built from 2:1 muxes, with valid/ready stages.
// Optional completed-transfer counter enabled by MUX_GATE_UNIT_PIPE_COUNT_EN.
module mux_gate_unit_pipe
  import mux_gate_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [1:0]         op,
  output logic               down_valid,
  input  logic               down_ready,
  output logic [W-1:0]       res,
  output logic [1:0]         op_out,
  output logic [COUNT_W-1:0] count
);

  localparam logic [W-1:0] ZEROS = '0;
  localparam logic [W-1:0] ONES  = '1;

  gate_op_t     w_op_sel;
  logic [W-1:0] w_b_n;
  logic [W-1:0] w_sel_op0;
  logic [W-1:0] w_sel_op1;
  logic [W-1:0] w_and;
  logic [W-1:0] w_or;
  logic [W-1:0] w_xor;
  logic [W-1:0] w_not;
  logic [W-1:0] w_dec_lo;
  logic [W-1:0] w_dec_hi;

  logic [DEPTH:0] w_valid;
  logic [W-1:0]   w_res [0:DEPTH];
  logic [1:0]     w_op  [0:DEPTH];
  logic [DEPTH:1] w_load;

  assign w_op_sel  = gate_op_t'(op);
  assign w_b_n     = ~b;
  assign w_sel_op0 = {W{w_op_sel[0]}};
  assign w_sel_op1 = {W{w_op_sel[1]}};

  // Each gate uses operand A as the per-bit mux select.
  mux2_w #(.W(W)) u_and (.d0(ZEROS), .d1(b),     .sel(a), .y(w_and));
  mux2_w #(.W(W)) u_or  (.d0(b),     .d1(ONES),  .sel(a), .y(w_or));
  mux2_w #(.W(W)) u_xor (.d0(b),     .d1(w_b_n), .sel(a), .y(w_xor));
  mux2_w #(.W(W)) u_not (.d0(ONES),  .d1(ZEROS), .sel(a), .y(w_not));

  // 4:1 op decode as a tree of three 2:1 muxes.
  mux2_w #(.W(W)) u_dec_lo (.d0(w_and),    .d1(w_or),     .sel(w_sel_op0), .y(w_dec_lo));
  mux2_w #(.W(W)) u_dec_hi (.d0(w_xor),    .d1(w_not),    .sel(w_sel_op0), .y(w_dec_hi));
  mux2_w #(.W(W)) u_dec    (.d0(w_dec_lo), .d1(w_dec_hi), .sel(w_sel_op1), .y(w_res[0]));

  assign w_valid[0] = up_valid;
  assign w_op[0]    = op;

  // A stage may load when empty or when it hands off; resolved from the output end backwards.
  always_comb begin
    logic l_ld;
    w_load = '0;
    l_ld   = down_ready;
    for (int k = DEPTH; k >= 1; k--) begin
      l_ld      = !w_valid[k] || l_ld;
      w_load[k] = l_ld;
    end
  end

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    logic         r_valid;
    logic [W-1:0] r_res;
    logic [1:0]   r_op;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
      end else if (w_load[k]) begin
        r_valid <= w_valid[k-1];
      end
    end

    // Payload is unreset and only moves with a valid item.
    always_ff @(posedge clk) begin
      if (w_load[k] && w_valid[k-1]) begin
        r_res <= w_res[k-1];
        r_op  <= w_op[k-1];
      end
    end

    assign w_valid[k] = r_valid;
    assign w_res[k]   = r_res;
    assign w_op[k]    = r_op;
  end

  assign up_ready   = w_load[1];
  assign down_valid = w_valid[DEPTH];
  assign res        = w_res[DEPTH];
  assign op_out     = w_op[DEPTH];

`ifdef MUX_GATE_UNIT_PIPE_COUNT_EN
  logic [COUNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (down_valid && down_ready) begin
      r_count <= r_count + COUNT_W'(1);
    end
  end

  assign count = r_count;
`else
  assign count = '0;
`endif

endmodule
